dmem_bridge: RTL
================

Name: dmem_bridge

Overview:
- Data-memory bridge sitting directly downstream of the single-cycle MIPS/FPU core's data-memory port (active-low CEN/WEN/OEN, 7-bit word address, 32-bit data).
- Converts each core access into one or two valid/ready transactions on a variable-latency memory slave.
- Stalls the core until the access completes, including both halves of a double-precision FP load/store.
- Replaces the core's self-sequenced second-word access with a single stalled 64-bit access.

Parameters:
- ADDR_W, 7: word-address width on both sides.
- DATA_W, 32: memory word width; core double width is 2*DATA_W.
- TIMEOUT, 64: watchdog limit in cycles (used only with DMEM_TIMEOUT_EN).

Ports:
- clk  in  1  Single clock; all state updates on rising edge.
- rst  in  1  Synchronous, active-high reset.
- core_cen  in  1  Access request, active low.
- core_wen  in  1  0 = write, 1 = read.
- core_oen  in  1  Read output enable, active low; ignored for sequencing.
- core_dbl  in  1  1 = two-word (double) access at core_a and core_a+1.
- core_a  in  ADDR_W  Word address.
- core_wdata  in  2*DATA_W  Write data; [31:0] goes to core_a, [63:32] to core_a+1.
- core_q  out  2*DATA_W  Read data, valid in DONE; upper half 0 for single-word reads.
- core_stall  out  1  1 = core must hold PC and all state.
- mem_req  out  1  Slave request valid.
- mem_we  out  1  Slave write strobe, qualified by mem_req.
- mem_addr  out  ADDR_W  Slave word address.
- mem_wdata  out  DATA_W  Slave write data.
- mem_gnt  in  1  Slave accepts request; handshake fires on mem_req&mem_gnt.
- mem_rvalid  in  1  Read data valid on mem_rdata.
- mem_rdata  in  DATA_W  Slave read data.
- err  out  1  Sticky timeout flag; constant 0 without the macro.

Behaviour:
- Reset (rst=1 at an edge):
  - state=IDLE; mem_req=0, mem_we=0, mem_addr=0, mem_wdata=0, core_q=0, err=0.
  - core_stall follows its combinational rule and is 0 in IDLE without a request.
- States: IDLE, REQ0, RD0, REQ1, RD1, DONE.
- core_stall = (IDLE & ~core_cen) | (state not in {IDLE, DONE}). It is combinational, so the core never advances on the cycle the request appears.
- IDLE:
  - core_cen=0 → latch core_a, core_wdata, core_wen, core_dbl; go to REQ0.
  - Any mem_rvalid is ignored.
- REQ0:
  - Drives mem_req=1, mem_addr=a, mem_we=~wen, mem_wdata=wdata[31:0].
  - mem_req, mem_addr, mem_we and mem_wdata stay stable until mem_gnt.
  - On gnt, a write goes to REQ1 if dbl, else DONE.
  - On gnt, a read goes to RD0; if mem_rvalid is also high that cycle, the data is captured and RD0 is skipped.
- RD0:
  - mem_req=0.
  - On mem_rvalid, capture mem_rdata into core_q[31:0]; go to REQ1 if dbl, else DONE.
- REQ1/RD1: same as REQ0/RD0 with mem_addr=(a+1) mod 2^ADDR_W (127 wraps to 0), data half [63:32].
- DONE:
  - core_stall=0 for exactly one cycle; core_q held.
  - Next state is IDLE unconditionally. The core's PC advances at this edge, so the same instruction is never re-issued.
  - core_q holds its value until the next read capture.
- Read latency (gnt and rvalid same cycle): single = 2 stall cycles, double = 3.
- rst mid-transaction:
  - Abort to IDLE and drop mem_req immediately.
  - A late mem_rvalid is ignored in IDLE.
  - A write already granted stays committed at the slave.

Optional Feature:
- Macro: DMEM_TIMEOUT_EN.
- With the macro:
  - A counter clears on entry to each REQ/RD state and increments each cycle in it.
  - When the count reaches TIMEOUT: set err (sticky until rst), force the current half of core_q to 32'hDEADBEEF, skip any remaining half, go to DONE.
- Without the macro: no counter; err tied to 0; the bridge waits indefinitely.

Decomposition:
- Package dmem_pkg:
  - state encoding (3-bit: IDLE=0, REQ0=1, RD0=2, REQ1=3, RD1=4, DONE=5);
  - DMEM_POISON = 32'hDEADBEEF;
  - default widths.
- Optional sub-module dmem_watchdog (counter, clear, expire output), instantiated only under DMEM_TIMEOUT_EN.
- The FSM and datapath stay in dmem_bridge.

Test Plan:
- Single read at a=5, slave gnt immediately with rvalid 2 cycles later, rdata=32'h12345678 → stall high 4 cycles; DONE shows core_q=64'h0000_0000_1234_5678; mem_addr=5 while mem_req=1.
- Double write at a=127, wdata=64'hAAAA_BBBB_CCCC_DDDD, gnt held low 3 cycles → first beat addr=127 data=CCCCDDDD stable all 3 cycles; second beat addr=0 data=AAAABBBB; no rvalid wait.
- Double read at a=10, zero-latency slave (gnt&rvalid same cycle, rdata=addr) → stall exactly 3 cycles; core_q=64'h0000000B_0000000A.
- Back-to-back reads at a=1 then a=2 on consecutive instructions → exactly one mem_req handshake per instruction; DONE→IDLE spacing verified.
- rst asserted while in RD0 and rvalid arriving the next cycle → state IDLE, mem_req=0, core_q unchanged from reset value 0, no capture.
- DMEM_TIMEOUT_EN, TIMEOUT=8, gnt never asserted → at cycle 8 err=1, core_q[31:0]=32'hDEADBEEF, DONE; err stays 1 until rst.

Source files
------------

// File: rtl/dmem_pkg.sv
// Shared state encoding, poison word and default widths for the data-memory bridge.
package dmem_pkg;

    localparam int DMEM_ADDR_W  = 7;
    localparam int DMEM_DATA_W  = 32;
    localparam int DMEM_TIMEOUT = 64;

    localparam logic [31:0] DMEM_POISON = 32'hDEADBEEF;

    typedef enum logic [2:0] {
        IDLE = 3'd0,
        REQ0 = 3'd1,
        RD0  = 3'd2,
        REQ1 = 3'd3,
        RD1  = 3'd4,
        DONE = 3'd5
    } state_t;

endpackage

// File: rtl/dmem_bridge_watchdog.sv
// Per-state cycle counter for the bridge; compiled only when DMEM_TIMEOUT_EN is defined.
`ifdef DMEM_TIMEOUT_EN
module dmem_watchdog #(
    parameter int TIMEOUT = 64
) (
    input  logic clk,
    input  logic rst,
    input  logic clr_i,
    input  logic en_i,
    output logic expire_o
);

    localparam int CNT_W = $clog2(TIMEOUT + 1);

    logic [CNT_W-1:0] cnt_q;
    logic [CNT_W-1:0] cnt_d;

    // The count is zero on the first cycle of a state, so expiry lands after TIMEOUT cycles.
    assign expire_o = en_i && (cnt_q == CNT_W'(TIMEOUT - 1));

    always_comb begin
        cnt_d = cnt_q;
        if (clr_i) begin
            cnt_d = '0;
        end else if (en_i && !expire_o) begin
            cnt_d = cnt_q + CNT_W'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

endmodule
`endif

// File: rtl/dmem_bridge.sv
// Stalls the core while each data access (one or two words) runs on a valid/ready memory slave.
// Optional watchdog: define DMEM_TIMEOUT_EN.
module dmem_bridge
    import dmem_pkg::*;
#(
    parameter int ADDR_W  = DMEM_ADDR_W,
    parameter int DATA_W  = DMEM_DATA_W,
    parameter int TIMEOUT = DMEM_TIMEOUT
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                core_cen,
    input  logic                core_wen,
    input  logic                core_oen,
    input  logic                core_dbl,
    input  logic [ADDR_W-1:0]   core_a,
    input  logic [2*DATA_W-1:0] core_wdata,
    output logic [2*DATA_W-1:0] core_q,
    output logic                core_stall,
    output logic                mem_req,
    output logic                mem_we,
    output logic [ADDR_W-1:0]   mem_addr,
    output logic [DATA_W-1:0]   mem_wdata,
    input  logic                mem_gnt,
    input  logic                mem_rvalid,
    input  logic [DATA_W-1:0]   mem_rdata,
    output logic                err,
    output state_t              dbg_state
);

    state_t              state_q, state_d;
    logic [ADDR_W-1:0]   a_q;
    logic [2*DATA_W-1:0] wdata_q;
    logic                wen_q;
    logic                dbl_q;
    logic [2*DATA_W-1:0] q_q, q_d;
    logic [2*DATA_W-1:0] cap_lo;
    logic                req_c;
    logic [ADDR_W-1:0]   addr_c;
    logic [DATA_W-1:0]   wdata_c;
    logic                unused_oen;

    assign unused_oen = core_oen;
    assign dbg_state  = state_q;
    assign core_q     = q_q;

    // A single-word read clears the upper half; the first half of a double keeps it.
    assign cap_lo = {(dbl_q ? q_q[2*DATA_W-1:DATA_W] : {DATA_W{1'b0}}), mem_rdata};

    assign core_stall = ((state_q == IDLE) && !core_cen) ||
                        !((state_q == IDLE) || (state_q == DONE));

    // A reset mid-transaction drops the request in the same cycle.
    assign mem_req   = req_c && !rst;
    assign mem_we    = req_c && !wen_q && !rst;
    assign mem_addr  = addr_c;
    assign mem_wdata = wdata_c;

`ifdef DMEM_TIMEOUT_EN
    logic err_q, err_d;
    logic wd_expire;
    logic wd_clr;
    logic wd_en;

    assign wd_en  = (state_q == REQ0) || (state_q == RD0) ||
                    (state_q == REQ1) || (state_q == RD1);
    assign wd_clr = (state_d != state_q);
    assign err    = err_q;

    dmem_watchdog #(.TIMEOUT(TIMEOUT)) u_watchdog (
        .clk      (clk),
        .rst      (rst),
        .clr_i    (wd_clr),
        .en_i     (wd_en),
        .expire_o (wd_expire)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            err_q <= 1'b0;
        end else begin
            err_q <= err_d;
        end
    end
`else
    localparam int unused_timeout = TIMEOUT;
    assign err = 1'b0;
`endif

    always_comb begin
        state_d = state_q;
        q_d     = q_q;
        req_c   = 1'b0;
        addr_c  = '0;
        wdata_c = '0;
        unique case (state_q)
            IDLE: begin
                if (!core_cen) state_d = REQ0;
            end
            REQ0: begin
                req_c   = 1'b1;
                addr_c  = a_q;
                wdata_c = wdata_q[DATA_W-1:0];
                if (mem_gnt) begin
                    if (!wen_q) begin
                        state_d = dbl_q ? REQ1 : DONE;
                    end else if (mem_rvalid) begin
                        q_d     = cap_lo;
                        state_d = dbl_q ? REQ1 : DONE;
                    end else begin
                        state_d = RD0;
                    end
                end
            end
            RD0: begin
                if (mem_rvalid) begin
                    q_d     = cap_lo;
                    state_d = dbl_q ? REQ1 : DONE;
                end
            end
            REQ1: begin
                req_c   = 1'b1;
                addr_c  = a_q + ADDR_W'(1);
                wdata_c = wdata_q[2*DATA_W-1:DATA_W];
                if (mem_gnt) begin
                    if (!wen_q) begin
                        state_d = DONE;
                    end else if (mem_rvalid) begin
                        q_d[2*DATA_W-1:DATA_W] = mem_rdata;
                        state_d                = DONE;
                    end else begin
                        state_d = RD1;
                    end
                end
            end
            RD1: begin
                if (mem_rvalid) begin
                    q_d[2*DATA_W-1:DATA_W] = mem_rdata;
                    state_d                = DONE;
                end
            end
            DONE:    state_d = IDLE;
            default: state_d = IDLE;
        endcase
`ifdef DMEM_TIMEOUT_EN
        err_d = err_q;
        // Expiry only wins when the slave did not complete the current step this cycle.
        if (wd_expire && (state_d == state_q)) begin
            err_d   = 1'b1;
            state_d = DONE;
            if ((state_q == REQ0) || (state_q == RD0)) begin
                q_d[DATA_W-1:0] = DATA_W'(DMEM_POISON);
            end else begin
                q_d[2*DATA_W-1:DATA_W] = DATA_W'(DMEM_POISON);
            end
        end
`endif
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= IDLE;
            a_q     <= '0;
            wdata_q <= '0;
            wen_q   <= 1'b1;
            dbl_q   <= 1'b0;
            q_q     <= '0;
        end else begin
            state_q <= state_d;
            q_q     <= q_d;
            if ((state_q == IDLE) && !core_cen) begin
                a_q     <= core_a;
                wdata_q <= core_wdata;
                wen_q   <= core_wen;
                dbl_q   <= core_dbl;
            end
        end
    end

endmodule
